// File: rtl/cdc_handshake_transmitter_if.sv
// ---------------------------------------------------------------------------
// cdc_handshake_transmitter_if
//
// Bundles the local send interface and the crossing-side req/ack/data wires
// of the four-phase handshake transmitter.
//
//   tx_data   word to send, sampled when the transmitter accepts it
//   tx_valid  local request to send tx_data
//   tx_ready  transmitter can accept a word (idle)
//   tx_done   one-cycle pulse when a handshake has fully completed
//   cdc_data  word held stable across the crossing
//   cdc_req   crossing request towards the destination domain
//   cdc_ack   asynchronous acknowledge returning from the destination domain
//
// master: the transmitter's view.  slave: the local sender plus the
// destination side, i.e. everything that talks to the transmitter.
// ---------------------------------------------------------------------------
interface cdc_handshake_transmitter_if #(
   parameter int BUS_WIDTH = 8
);
   logic [BUS_WIDTH-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx_done;
   logic [BUS_WIDTH-1:0] cdc_data;
   logic                 cdc_req;
   logic                 cdc_ack;

   modport master (
      input  tx_data,
      input  tx_valid,
      input  cdc_ack,
      output tx_ready,
      output tx_done,
      output cdc_data,
      output cdc_req
   );

   modport slave (
      output tx_data,
      output tx_valid,
      output cdc_ack,
      input  tx_ready,
      input  tx_done,
      input  cdc_data,
      input  cdc_req
   );
endinterface

// File: rtl/cdc_handshake_transmitter.sv
// ---------------------------------------------------------------------------
// cdc_handshake_transmitter
//
// Source-domain end of a four-phase req/ack clock-domain crossing. One word
// is accepted per handshake and held on cdc_data; cdc_req is raised, the
// returning cdc_ack is synchronized through a STAGE_COUNT-deep flop chain,
// and the return-to-zero phase completes before the next word is accepted.
//
// Parameters
//   BUS_WIDTH    width of the crossing data word
//   STAGE_COUNT  depth of the cdc_ack synchronizer chain (2 or more)
//
// Ports
//   clk    source-domain clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    cdc_handshake_transmitter_if.master (tx_* local side, cdc_* crossing)
// ---------------------------------------------------------------------------
module cdc_handshake_transmitter #(
   parameter int BUS_WIDTH   = 8,
   parameter int STAGE_COUNT = 2
) (
   input logic                          clk,
   input logic                          reset,
   cdc_handshake_transmitter_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      REQ,
      DROP
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [STAGE_COUNT-1:0] ack_chain;
   logic                   ack_sync;
   logic                   accept;
   logic [BUS_WIDTH-1:0]   cdc_data_q;
   logic                   cdc_req_q;
   logic                   tx_done_q;

   // cdc_ack is asynchronous to clk, so it is only ever looked at through
   // this shift chain; the last stage is the only copy the FSM may use.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_chain <= '0;
      end else begin
         ack_chain <= {ack_chain[STAGE_COUNT-2:0], bus.cdc_ack};
      end
   end

   assign ack_sync = ack_chain[STAGE_COUNT-1];
   assign accept   = (state == IDLE) && bus.tx_valid;

   // State register. Reset drops straight back to IDLE, which abandons any
   // word in flight without a completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. SETUP waits out any ack still high from an earlier
   // (possibly reset-abandoned) transfer so it is never mistaken for the
   // acknowledgement of the new word.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)    next_state = SETUP;
         SETUP:   if (!ack_sync) next_state = REQ;
         REQ:     if (ack_sync)  next_state = DROP;
         DROP:    if (!ack_sync) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // Registered outputs. cdc_req follows the state being entered so it is a
   // clean flop output; the data word only ever loads on acceptance, so it
   // is already stable a full cycle before cdc_req rises.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdc_data_q <= '0;
         cdc_req_q  <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         if (accept) begin
            cdc_data_q <= bus.tx_data;
         end
         cdc_req_q <= (next_state == REQ);
         tx_done_q <= (state == DROP) && !ack_sync;
      end
   end

   assign bus.tx_ready = (state == IDLE);
   assign bus.tx_done  = tx_done_q;
   assign bus.cdc_data = cdc_data_q;
   assign bus.cdc_req  = cdc_req_q;

endmodule

// File: tb/tb_cdc_handshake_transmitter.sv
// ---------------------------------------------------------------------------
// tb_cdc_handshake_transmitter
//
// Self-checking bench for cdc_handshake_transmitter. A transaction-level
// model predicts, for each accepted word, the edge at which cdc_req rises,
// how long it stays high and the edge of the tx_done pulse, from the
// handshake timing rules and the echo delay of the bench's ack responder.
// ---------------------------------------------------------------------------
module tb_cdc_handshake_transmitter;

   localparam int BUS_WIDTH   = 8;
   localparam int STAGE_COUNT = 2;
   localparam int S           = STAGE_COUNT;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   cdc_handshake_transmitter_if #(.BUS_WIDTH(BUS_WIDTH)) bus ();

   cdc_handshake_transmitter #(
      .BUS_WIDTH   (BUS_WIDTH),
      .STAGE_COUNT (STAGE_COUNT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_cnt     = 0;

   // Transaction model: edge of acceptance, edge cdc_req rises, edge of the
   // tx_done pulse, and the echo delay in force for that word.
   int                   acc_edge  = -1;
   int                   rise_edge = 0;
   int                   done_edge = 0;
   int                   cur_d     = 0;
   int                   next_d    = 0;
   bit                   risen     = 1'b0;
   int                   last_high = -100;
   logic [BUS_WIDTH-1:0] exp_data  = '0;

   // Ack responder: echoes cdc_req back after cur_d edges when enabled.
   bit       echo_en  = 1'b1;
   logic [7:0] req_hist = '0;

   // Observation bookkeeping.
   logic prev_req      = 1'b0;
   int   req_rise_seen = -1;
   int   done_count    = 0;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)",
                  tag, observed, expected, edge_cnt);
      end
   endtask

   // One rising edge: update the model, check every output #1 later, then
   // let the responder drive cdc_ack for the following edge.
   task automatic clock_step();
      int   e;
      logic exp_req;
      logic exp_done;
      logic exp_ready;
      @(posedge clk);
      edge_cnt++;
      e = edge_cnt;
      if (bus.cdc_ack) last_high = e;
      if (reset && bus.tx_valid && (acc_edge < 0 || e > done_edge)) begin
         acc_edge = e;
         exp_data = bus.tx_data;
         cur_d    = next_d;
         risen    = 1'b0;
      end
      if (acc_edge >= 0 && !risen) begin
         rise_edge = (acc_edge + 1 > last_high + 1 + S) ? acc_edge + 1 : last_high + 1 + S;
         done_edge = rise_edge + 2 * S + 2 + 2 * cur_d;
         if (e >= rise_edge) risen = 1'b1;
      end
      exp_req   = (acc_edge >= 0) && risen && (e >= rise_edge) && (e <= rise_edge + S + cur_d);
      exp_done  = (acc_edge >= 0) && (e == done_edge);
      exp_ready = (acc_edge < 0) || (e >= done_edge);
      #1;
      check_output("cdc_data", bus.cdc_data, exp_data);
      check_output("cdc_req",  bus.cdc_req,  exp_req);
      check_output("tx_done",  bus.tx_done,  exp_done);
      check_output("tx_ready", bus.tx_ready, exp_ready);
      if (bus.tx_done) done_count++;
      if (!prev_req && bus.cdc_req) req_rise_seen = e;
      prev_req = bus.cdc_req;
      req_hist = {req_hist[6:0], bus.cdc_req};
      if (echo_en) bus.cdc_ack = req_hist[cur_d];
   endtask

   task automatic apply_stimulus(input logic valid, input logic [BUS_WIDTH-1:0] data,
                                 input int delay);
      bus.tx_valid = valid;
      bus.tx_data  = data;
      next_d       = delay;
      clock_step();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 0);
   endtask

   // Asserts reset mid-cycle and checks the asynchronous reset values
   // before any clock edge, then holds reset for two edges.
   task automatic reset_and_check();
      #3;
      reset = 1'b0;
      #1;
      check_output("rst_cdc_req",  bus.cdc_req,  1'b0);
      check_output("rst_cdc_data", bus.cdc_data, 8'h00);
      check_output("rst_tx_done",  bus.tx_done,  1'b0);
      check_output("rst_tx_ready", bus.tx_ready, 1'b1);
      acc_edge     = -1;
      exp_data     = '0;
      last_high    = -100;
      req_hist     = '0;
      cur_d        = 0;
      bus.cdc_ack  = 1'b0;
      bus.tx_valid = 1'b0;
      clock_step();
      clock_step();
      #3;
      reset = 1'b1;
   endtask

   int done_before;
   int first_done;
   int b2b_edge;
   int ack_drop_edge;

   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.cdc_ack  = 1'b0;
      #2;
      check_output("init_cdc_req",  bus.cdc_req,  1'b0);
      check_output("init_cdc_data", bus.cdc_data, 8'h00);
      check_output("init_tx_ready", bus.tx_ready, 1'b1);
      clock_step();
      clock_step();
      #3;
      reset = 1'b1;
      idle_cycles(2);

      // Single transfer, ack echoed three cycles after cdc_req.
      done_before = done_count;
      apply_stimulus(1'b1, 8'hA5, 3);
      idle_cycles(30);
      check_output("single_done_count", done_count - done_before, 1);

      // Back-to-back: valid held high across two words.
      done_before = done_count;
      for (int i = 0; i < 50 && bus.cdc_data !== 8'h01; i++) apply_stimulus(1'b1, 8'h01, 0);
      check_output("b2b_first_accept", bus.cdc_data, 8'h01);
      first_done = done_edge;
      b2b_edge   = -1;
      for (int i = 0; i < 50 && bus.cdc_data !== 8'h02; i++) apply_stimulus(1'b1, 8'h02, 0);
      if (bus.cdc_data === 8'h02) b2b_edge = edge_cnt;
      check_output("b2b_accept_edge", b2b_edge, first_done + 1);
      idle_cycles(30);
      check_output("b2b_done_count", done_count - done_before, 2);

      // Valid pulsed with 8'hFF while in REQ must be ignored.
      done_before = done_count;
      apply_stimulus(1'b1, 8'h3C, 1);
      for (int i = 0; i < 20 && bus.cdc_req !== 1'b1; i++) idle_cycles(1);
      check_output("ign_req_high", bus.cdc_req, 1'b1);
      apply_stimulus(1'b1, 8'hFF, 1);
      idle_cycles(30);
      check_output("ign_data", bus.cdc_data, 8'h3C);
      check_output("ign_done_count", done_count - done_before, 1);

      // Stale ack held high across acceptance.
      echo_en     = 1'b0;
      bus.cdc_ack = 1'b1;
      idle_cycles(5);
      apply_stimulus(1'b1, 8'h5A, 0);
      idle_cycles(6);
      check_output("stale_req_low", bus.cdc_req, 1'b0);
      bus.cdc_ack   = 1'b0;
      echo_en       = 1'b1;
      ack_drop_edge = edge_cnt + 1;
      req_rise_seen = -1;
      idle_cycles(30);
      check_output("stale_rise_edge", req_rise_seen, ack_drop_edge + S);

      // Reset while cdc_req is high, then a normal transfer.
      apply_stimulus(1'b1, 8'hC3, 3);
      for (int i = 0; i < 20 && bus.cdc_req !== 1'b1; i++) idle_cycles(1);
      check_output("midreq_req_high", bus.cdc_req, 1'b1);
      done_before = done_count;
      reset_and_check();
      idle_cycles(10);
      check_output("midreq_no_done", done_count - done_before, 0);
      apply_stimulus(1'b1, 8'h96, 0);
      idle_cycles(30);
      check_output("midreq_next_done", done_count - done_before, 1);

      // Randomized traffic with random echo delays.
      for (int i = 0; i < 600; i++) begin
         apply_stimulus(($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 3));
      end
      idle_cycles(30);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
